// File: rtl/atm_pkg.sv
// ----------------------------------------------------------------------------
// atm_pkg
// Shared definitions for the keypad entry path:
//   - key_t and the key code constants produced by the keypad decoder
//   - entry limits (MAX_DIGITS, MAX_VALUE)
//   - kp_state_t, the scan/debounce FSM state type
//   - helper functions that map a (row, column) pair to a key code and
//     classify a sampled column pattern
// No ports (package).
// ----------------------------------------------------------------------------
package atm_pkg;

    localparam int MAX_DIGITS = 2;
    localparam int MAX_VALUE  = 99;

    typedef logic [3:0] key_t;

    // Digits use their own value so they can feed the accumulator directly.
    localparam key_t KEY_0    = 4'd0;
    localparam key_t KEY_1    = 4'd1;
    localparam key_t KEY_2    = 4'd2;
    localparam key_t KEY_3    = 4'd3;
    localparam key_t KEY_4    = 4'd4;
    localparam key_t KEY_5    = 4'd5;
    localparam key_t KEY_6    = 4'd6;
    localparam key_t KEY_7    = 4'd7;
    localparam key_t KEY_8    = 4'd8;
    localparam key_t KEY_9    = 4'd9;
    localparam key_t KEY_CLR  = 4'd10;
    localparam key_t KEY_ENT  = 4'd11;
    localparam key_t KEY_BS   = 4'd12;
    localparam key_t KEY_NONE = 4'd15;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kp_state_t;

    // Keypad layout, column 0 leftmost:
    //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: * 0 # D
    // A, B and C carry no function and decode to KEY_NONE.
    function automatic key_t decode_key(input logic [1:0] row, input logic [1:0] col);
        key_t k;
        case ({row, col})
            4'h0:    k = KEY_1;
            4'h1:    k = KEY_2;
            4'h2:    k = KEY_3;
            4'h4:    k = KEY_4;
            4'h5:    k = KEY_5;
            4'h6:    k = KEY_6;
            4'h8:    k = KEY_7;
            4'h9:    k = KEY_8;
            4'hA:    k = KEY_9;
            4'hC:    k = KEY_CLR;
            4'hD:    k = KEY_0;
            4'hE:    k = KEY_ENT;
            4'hF:    k = KEY_BS;
            default: k = KEY_NONE;
        endcase
        return k;
    endfunction

    // True when exactly one column is pulled low.
    function automatic logic single_low(input logic [3:0] cols);
        return (cols == 4'b1110) || (cols == 4'b1101) ||
               (cols == 4'b1011) || (cols == 4'b0111);
    endfunction

    // Index of the low column in a single-low pattern.
    function automatic logic [1:0] col_index(input logic [3:0] cols);
        logic [1:0] idx;
        case (cols)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// ----------------------------------------------------------------------------
// keypad_debounce
// Scan/debounce/held state machine for the matrix keypad. All decisions
// are taken on tick_i, which marks the last clock of a row period.
//   SCAN     : any low column -> DEBOUNCE, the sampled pattern is latched
//   DEBOUNCE : DEB_CNT further identical single-low samples accept the key;
//              any change, release or multiple lows drops back to SCAN
//   HELD     : DEB_CNT consecutive all-high samples -> SCAN
// Ports:
//   clk_i        in   system clock, rising edge
//   rst_ni       in   asynchronous reset, active low
//   tick_i       in   one-cycle pulse at the end of each row period
//   col_i        in   keypad columns, active low
//   state_o      out  current FSM state (row stepping only in SCAN)
//   accept_o     out  one-cycle pulse the cycle after a key is accepted
//   accept_col_o out  column pattern of the accepted key
// ----------------------------------------------------------------------------
module keypad_debounce
    import atm_pkg::*;
#(
    parameter int DEB_CNT = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tick_i,
    input  logic [3:0] col_i,
    output kp_state_t  state_o,
    output logic       accept_o,
    output logic [3:0] accept_col_o
);

    localparam logic [3:0] LAST_SAMPLE = 4'(DEB_CNT - 1);

    kp_state_t  state_q, state_d;
    logic [3:0] pattern_q, pattern_d;
    logic [3:0] count_q, count_d;
    logic       accept_q, accept_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SCAN;
            pattern_q <= 4'b1111;
            count_q   <= 4'd0;
            accept_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            count_q   <= count_d;
            accept_q  <= accept_d;
        end
    end

    // count_q counts matching resamples in DEBOUNCE and consecutive
    // all-high samples in HELD; it is cleared on every state change.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        count_d   = count_q;
        accept_d  = 1'b0;
        if (tick_i) begin
            case (state_q)
                SCAN: begin
                    if (col_i != 4'b1111) begin
                        state_d   = DEBOUNCE;
                        pattern_d = col_i;
                        count_d   = 4'd0;
                    end
                end
                DEBOUNCE: begin
                    if ((col_i == pattern_q) && single_low(col_i)) begin
                        if (count_q == LAST_SAMPLE) begin
                            state_d  = HELD;
                            accept_d = 1'b1;
                            count_d  = 4'd0;
                        end else begin
                            count_d = count_q + 4'd1;
                        end
                    end else begin
                        state_d = SCAN;
                        count_d = 4'd0;
                    end
                end
                HELD: begin
                    if (col_i == 4'b1111) begin
                        if (count_q == LAST_SAMPLE) begin
                            state_d = SCAN;
                            count_d = 4'd0;
                        end else begin
                            count_d = count_q + 4'd1;
                        end
                    end else begin
                        count_d = 4'd0;
                    end
                end
                default: begin
                    state_d = SCAN;
                    count_d = 4'd0;
                end
            endcase
        end
    end

    assign state_o      = state_q;
    assign accept_o     = accept_q;
    assign accept_col_o = pattern_q;

endmodule

// File: rtl/keypad_enc.sv
// ----------------------------------------------------------------------------
// keypad_enc
// 4x4 matrix keypad scanner and two-digit decimal entry encoder.
// Rows are driven one-hot active-low, each for SCAN_DIV clocks; a pressed
// key is debounced by keypad_debounce, decoded, and folded into a 0..99
// accumulator. '*' clears the entry, '#' publishes it on num with a
// one-cycle num_valid pulse.
// Optional feature macro: KEYPAD_ENC_BACKSPACE_EN -- when defined, 'D'
// removes the last entered digit; when undefined 'D' is ignored and no
// divider is built.
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   key_col   in   keypad columns, active low (external pull-ups)
//   key_row   out  keypad row drive, one-hot active low
//   num       out  last entered value 0..99 (binary, bits [9:7] zero)
//   num_valid out  one-cycle pulse when num updates
//   digit_cnt out  digits currently in the entry buffer (0..2)
// ----------------------------------------------------------------------------
module keypad_enc
    import atm_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEB_CNT  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [9:0] num,
    output logic       num_valid,
    output logic [1:0] digit_cnt
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] divCnt_q, divCnt_d;
    logic [1:0]  rowIdx_q, rowIdx_d;
    logic [6:0]  acc_q, acc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [6:0]  num_q, num_d;
    logic        valid_q, valid_d;

    logic        tick;
    kp_state_t   fsmState;
    logic        keyAccept;
    logic [3:0]  keyCols;
    key_t        keyCode;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divCnt_q <= 16'd0;
            rowIdx_q <= 2'd0;
            acc_q    <= 7'd0;
            cnt_q    <= 2'd0;
            num_q    <= 7'd0;
            valid_q  <= 1'b0;
        end else begin
            divCnt_q <= divCnt_d;
            rowIdx_q <= rowIdx_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            num_q    <= num_d;
            valid_q  <= valid_d;
        end
    end

    // The row-period divider runs in every state so DEBOUNCE and HELD
    // resample once per row period. The row only steps in SCAN when no
    // column is low; otherwise the FSM leaves SCAN and the row stays frozen
    // on the pressed key's row.
    always_comb begin
        tick     = (divCnt_q == DIV_LAST);
        divCnt_d = tick ? 16'd0 : divCnt_q + 16'd1;
        rowIdx_d = rowIdx_q;
        if (tick && (fsmState == SCAN) && (key_col == 4'b1111)) begin
            rowIdx_d = rowIdx_q + 2'd1;
        end
    end

    assign key_row = ~(4'b0001 << rowIdx_q);

    keypad_debounce #(
        .DEB_CNT (DEB_CNT)
    ) u_debounce (
        .clk_i        (clk),
        .rst_ni       (rst),
        .tick_i       (tick),
        .col_i        (key_col),
        .state_o      (fsmState),
        .accept_o     (keyAccept),
        .accept_col_o (keyCols)
    );

    // rowIdx_q is still frozen on the pressed row while the key is HELD.
    assign keyCode = keyAccept ? decode_key(rowIdx_q, col_index(keyCols)) : KEY_NONE;

    // Entry logic. A digit is only appended while fewer than MAX_DIGITS are
    // buffered, so acc*10+digit stays within MAX_VALUE.
    always_comb begin
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        valid_d = 1'b0;
        if (keyCode <= KEY_9) begin
            if (cnt_q < 2'(MAX_DIGITS)) begin
                acc_d = 7'(acc_q * 7'd10) + {3'b000, keyCode};
                cnt_d = cnt_q + 2'd1;
            end
        end else if (keyCode == KEY_CLR) begin
            acc_d = 7'd0;
            cnt_d = 2'd0;
        end else if (keyCode == KEY_ENT) begin
            num_d   = acc_q;
            valid_d = 1'b1;
            acc_d   = 7'd0;
            cnt_d   = 2'd0;
        end
`ifdef KEYPAD_ENC_BACKSPACE_EN
        else if (keyCode == KEY_BS) begin
            if (cnt_q != 2'd0) begin
                acc_d = acc_q / 7'd10;
                cnt_d = cnt_q - 2'd1;
            end
        end
`endif
    end

    assign num       = {3'b000, num_q};
    assign num_valid = valid_q;
    assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_keypad_enc.sv
// ----------------------------------------------------------------------------
// tb_keypad_enc
// Scoreboard bench for keypad_enc (SCAN_DIV=4, DEB_CNT=2). A keypad model
// pulls a column low only while the pressed key's row is driven. Expected
// '#' results are queued when issued; a monitor pops them on num_valid.
// ----------------------------------------------------------------------------
module tb_keypad_enc;

    localparam int SCAN_DIV = 4;
    localparam int DEB_CNT  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic [9:0] num;
    logic       num_valid;
    logic [1:0] digit_cnt;

    logic       pressed = 1'b0;
    logic [1:0] pRow = 2'd0;
    logic [1:0] pCol = 2'd0;

    int         compared   = 0;
    int         mismatched = 0;
    logic [9:0] expQ[$];
    logic [9:0] expVal;

    // Clock generation.
    always #5 clk = ~clk;

    // Keypad model: the column reads low only while its row is driven.
    assign key_col = (pressed && (key_row[pRow] == 1'b0)) ? ~(4'b0001 << pCol) : 4'b1111;

    keypad_enc #(
        .SCAN_DIV (SCAN_DIV),
        .DEB_CNT  (DEB_CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_col   (key_col),
        .key_row   (key_row),
        .num       (num),
        .num_valid (num_valid),
        .digit_cnt (digit_cnt)
    );

    // Compare one value and log a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Advance n falling edges.
    task automatic waitClks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press one key by its legend, hold it, then release and let HELD expire.
    task automatic applyStimulus(input byte key, input int holdClks = 40);
        case (key)
            "1": begin pRow = 2'd0; pCol = 2'd0; end
            "2": begin pRow = 2'd0; pCol = 2'd1; end
            "3": begin pRow = 2'd0; pCol = 2'd2; end
            "A": begin pRow = 2'd0; pCol = 2'd3; end
            "4": begin pRow = 2'd1; pCol = 2'd0; end
            "5": begin pRow = 2'd1; pCol = 2'd1; end
            "6": begin pRow = 2'd1; pCol = 2'd2; end
            "B": begin pRow = 2'd1; pCol = 2'd3; end
            "7": begin pRow = 2'd2; pCol = 2'd0; end
            "8": begin pRow = 2'd2; pCol = 2'd1; end
            "9": begin pRow = 2'd2; pCol = 2'd2; end
            "C": begin pRow = 2'd2; pCol = 2'd3; end
            "*": begin pRow = 2'd3; pCol = 2'd0; end
            "0": begin pRow = 2'd3; pCol = 2'd1; end
            "#": begin pRow = 2'd3; pCol = 2'd2; end
            default: begin pRow = 2'd3; pCol = 2'd3; end
        endcase
        @(negedge clk);
        pressed = 1'b1;
        waitClks(holdClks);
        pressed = 1'b0;
        waitClks(24);
    endtask

    // Monitor: every num_valid pulse must match the next queued value and
    // last exactly one cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && num_valid) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_pulse: num=%0d, expected no pulse", num);
                end else begin
                    expVal = expQ.pop_front();
                    checkOutput("num", 16'(num), 16'(expVal));
                end
                @(negedge clk);
                checkOutput("pulse_width", 16'(num_valid), 16'd0);
            end
        end
    end

    initial begin
        // Reset state.
        rst = 1'b0;
        waitClks(3);
        checkOutput("rst_key_row",   16'(key_row),   16'hE);
        checkOutput("rst_num",       16'(num),       16'd0);
        checkOutput("rst_num_valid", 16'(num_valid), 16'd0);
        checkOutput("rst_digit_cnt", 16'(digit_cnt), 16'd0);

        // First row advance SCAN_DIV clocks after release.
        rst = 1'b1;
        waitClks(SCAN_DIV - 1);
        checkOutput("row_before_first_step", 16'(key_row), 16'hE);
        waitClks(1);
        checkOutput("row_first_step", 16'(key_row), 16'hD);

        // 4, A (ignored), 2, # -> 42.
        applyStimulus("4");
        applyStimulus("A");
        applyStimulus("2");
        checkOutput("cnt_after_42", 16'(digit_cnt), 16'd2);
        expQ.push_back(10'd42);
        applyStimulus("#");
        checkOutput("cnt_after_ent42", 16'(digit_cnt), 16'd0);

        // 1, 2, 3 (dropped), # -> 12.
        applyStimulus("1");
        applyStimulus("2");
        applyStimulus("3");
        checkOutput("cnt_after_123", 16'(digit_cnt), 16'd2);
        expQ.push_back(10'd12);
        applyStimulus("#");

        // 5, *, 7, # -> 7; then # alone -> 0.
        applyStimulus("5");
        applyStimulus("*");
        checkOutput("cnt_after_clr", 16'(digit_cnt), 16'd0);
        applyStimulus("7");
        expQ.push_back(10'd7);
        applyStimulus("#");
        expQ.push_back(10'd0);
        applyStimulus("#");

        // Bouncing '8': column toggles every row period.
        pRow = 2'd2;
        pCol = 2'd1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            pressed = ~pressed;
            waitClks(SCAN_DIV);
        end
        pressed = 1'b0;
        waitClks(24);
        checkOutput("cnt_after_bounce", 16'(digit_cnt), 16'd0);

        // Long hold of '9' counts once.
        applyStimulus("9", 50 * SCAN_DIV);
        checkOutput("cnt_after_long_hold", 16'(digit_cnt), 16'd1);

        // Reset during the second '9'.
        pRow = 2'd2;
        pCol = 2'd2;
        pressed = 1'b1;
        waitClks(18);
        rst = 1'b0;
        #1;
        checkOutput("midrst_key_row",   16'(key_row),   16'hE);
        checkOutput("midrst_num",       16'(num),       16'd0);
        checkOutput("midrst_num_valid", 16'(num_valid), 16'd0);
        checkOutput("midrst_digit_cnt", 16'(digit_cnt), 16'd0);
        waitClks(2);
        pressed = 1'b0;
        waitClks(2);
        rst = 1'b1;
        waitClks(40);
        checkOutput("postrst_digit_cnt", 16'(digit_cnt), 16'd0);
        checkOutput("postrst_num",       16'(num),       16'd0);

        // 6, 3, D, #.
        applyStimulus("6");
        applyStimulus("3");
        applyStimulus("D");
`ifdef KEYPAD_ENC_BACKSPACE_EN
        checkOutput("cnt_after_bs", 16'(digit_cnt), 16'd1);
        expQ.push_back(10'd6);
`else
        checkOutput("cnt_after_bs", 16'(digit_cnt), 16'd2);
        expQ.push_back(10'd63);
`endif
        applyStimulus("#");

        waitClks(10);
        checkOutput("queue_empty", 16'(expQ.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
